// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder/retirement buffer.
//   rob_entry_t : one buffer slot (mapping created by a dispatched instruction)
//   rob_state_e : retirement FSM states
//   ptr_inc/dec : circular pointer stepping with explicit wrap
// Build option: ROB_EXC_EN adds the per-entry fault bit used by the flush walk.
package rob_pkg;

  localparam int unsigned ROB_ARCH  = 32;
  localparam int unsigned ROB_PHYS  = 64;
  localparam int unsigned ROB_PW    = 6;
  localparam int unsigned ROB_AW    = 5;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_TW    = 4;

  typedef struct packed {
    logic              valid;
    logic              done;
`ifdef ROB_EXC_EN
    logic              exc;
`endif
    logic              has_dst;
    logic [ROB_AW-1:0] ard;
    logic [ROB_PW-1:0] prd_new;
    logic [ROB_PW-1:0] prd_old;
  } rob_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_state_e;

  function automatic logic [ROB_TW-1:0] ptr_inc(input logic [ROB_TW-1:0] p);
    return (p == ROB_TW'(ROB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ROB_TW-1:0] ptr_dec(input logic [ROB_TW-1:0] p);
    return (p == '0) ? ROB_TW'(ROB_DEPTH - 1) : p - 1'b1;
  endfunction

endpackage

// File: rtl/rob_retire_if.sv
// Bundle of dispatch, completion, commit, free-list and rollback signals of rob_retire.
//   master : rename/dispatch + execution side (drives disp_* requests and cmpl_*)
//   slave  : the retirement buffer (drives ready/tag, commit_*, free_*, rb_*, flush_*, count)
interface rob_retire_if #(
  parameter int unsigned AW = rob_pkg::ROB_AW,
  parameter int unsigned PW = rob_pkg::ROB_PW,
  parameter int unsigned TW = rob_pkg::ROB_TW
) ();

  logic          disp_valid;
  logic          disp_ready;
  logic          disp_has_dst;
  logic [AW-1:0] disp_ard;
  logic [PW-1:0] disp_prd_new;
  logic [PW-1:0] disp_prd_old;
  logic [TW-1:0] disp_tag;

  logic          cmpl_valid;
  logic [TW-1:0] cmpl_tag;
  logic          cmpl_exc;

  logic          commit_valid;
  logic [AW-1:0] commit_ard;
  logic [PW-1:0] commit_prd;

  logic          free_en;
  logic [PW-1:0] prd_free;

  logic          rb_valid;
  logic [AW-1:0] rb_ard;
  logic [PW-1:0] rb_prd_old;

  logic          flush_start;
  logic          flush_done;
  logic [TW:0]   count;

  modport master (
    output disp_valid, disp_has_dst, disp_ard, disp_prd_new, disp_prd_old,
    output cmpl_valid, cmpl_tag, cmpl_exc,
    input  disp_ready, disp_tag, commit_valid, commit_ard, commit_prd,
    input  free_en, prd_free, rb_valid, rb_ard, rb_prd_old,
    input  flush_start, flush_done, count
  );

  modport slave (
    input  disp_valid, disp_has_dst, disp_ard, disp_prd_new, disp_prd_old,
    input  cmpl_valid, cmpl_tag, cmpl_exc,
    output disp_ready, disp_tag, commit_valid, commit_ard, commit_prd,
    output free_en, prd_free, rb_valid, rb_ard, rb_prd_old,
    output flush_start, flush_done, count
  );

endinterface

// File: rtl/rob_retire.sv
// In-order retirement buffer between rename/dispatch and the physical free list.
// Commits the oldest completed entry (returns prd_old, updates the architectural map);
// on a faulting head it walks youngest->oldest, returning prd_new and emitting
// rollback mappings.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active low
//   rob_if : rob_retire_if.slave (dispatch, completion, commit, free, rollback, count)
// Build option: ROB_EXC_EN enables fault detection and the FLUSH walk; without it the
// FSM is RUN-only, cmpl_exc is ignored and rb_*/flush_* are held at 0.
module rob_retire
  import rob_pkg::*;
#(
  parameter int unsigned ARCH  = ROB_ARCH,
  parameter int unsigned PHYS  = ROB_PHYS,
  parameter int unsigned PW    = ROB_PW,
  parameter int unsigned AW    = ROB_AW,
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TW    = ROB_TW
) (
  input  logic        clk,
  input  logic        rst,
  rob_retire_if.slave rob_if
);

  // Entry fields are sized from the package; these only describe the configuration.
  localparam int unsigned unused_cfg = ARCH + PHYS + PW + AW;
  localparam logic [TW:0] FullCount  = (TW + 1)'(DEPTH);

  rob_entry_t    entries_q [DEPTH];
  rob_entry_t    entries_d [DEPTH];
  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [TW:0]   count_q, count_d;

  rob_entry_t    head_e, last_e, new_e;
  logic [TW-1:0] last_idx;
  logic          in_run, in_flush, head_exc;
  logic          disp_ready, disp_fire, head_ready, commit, fault, walk, flush_done;

`ifdef ROB_EXC_EN
  rob_state_e state_q, state_d;

  assign in_run   = (state_q == RUN);
  assign in_flush = (state_q == FLUSH);
  assign head_exc = head_e.exc;
`else
  logic unused_cmpl_exc;

  assign in_run          = 1'b1;
  assign in_flush        = 1'b0;
  assign head_exc        = 1'b0;
  assign unused_cmpl_exc = rob_if.cmpl_exc;
`endif

  assign head_e   = entries_q[head_q];
  assign last_idx = ptr_dec(tail_q);
  assign last_e   = entries_q[last_idx];

  // Ready is forced low while reset is held, not just from the registered state.
  assign disp_ready = rst & in_run & (count_q != FullCount);
  assign disp_fire  = rob_if.disp_valid & disp_ready;
  assign head_ready = in_run & head_e.valid & head_e.done;
  assign commit     = head_ready & ~head_exc;
  assign fault      = head_ready & head_exc;
  assign walk       = in_flush & (count_q != '0);
  assign flush_done = in_flush & (count_q == '0);

  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.has_dst = rob_if.disp_has_dst;
    new_e.ard     = rob_if.disp_ard;
    new_e.prd_new = rob_if.disp_prd_new;
    new_e.prd_old = rob_if.disp_prd_old;
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (in_run) begin
      if (rob_if.cmpl_valid && entries_q[rob_if.cmpl_tag].valid) begin
        entries_d[rob_if.cmpl_tag].done = 1'b1;
`ifdef ROB_EXC_EN
        entries_d[rob_if.cmpl_tag].exc  = rob_if.cmpl_exc;
`endif
      end
      if (commit) begin
        entries_d[head_q] = '0;
        head_d            = ptr_inc(head_q);
      end
      // Dispatch is refused when full, so tail never collides with the committing head.
      if (disp_fire) begin
        entries_d[tail_q] = new_e;
        tail_d            = ptr_inc(tail_q);
      end
      count_d = count_q + {TW'(0), disp_fire} - {TW'(0), commit};
    end else if (walk) begin
      entries_d[last_idx] = '0;
      tail_d              = last_idx;
      count_d             = count_q - 1'b1;
    end
  end

`ifdef ROB_EXC_EN
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (fault) state_d = FLUSH;
      FLUSH:   if (flush_done) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  always_comb begin
    rob_if.disp_ready   = disp_ready;
    rob_if.disp_tag     = tail_q;
    rob_if.count        = count_q;
    rob_if.commit_valid = commit;
    rob_if.commit_ard   = '0;
    rob_if.commit_prd   = '0;
    rob_if.free_en      = 1'b0;
    rob_if.prd_free     = '0;
    rob_if.rb_valid     = 1'b0;
    rob_if.rb_ard       = '0;
    rob_if.rb_prd_old   = '0;
    rob_if.flush_start  = fault;
    rob_if.flush_done   = flush_done;
    if (commit && head_e.has_dst) begin
      rob_if.commit_ard = head_e.ard;
      rob_if.commit_prd = head_e.prd_new;
      rob_if.free_en    = 1'b1;
      rob_if.prd_free   = head_e.prd_old;
    end
    if (walk && last_e.has_dst) begin
      rob_if.rb_valid   = 1'b1;
      rob_if.rb_ard     = last_e.ard;
      rob_if.rb_prd_old = last_e.prd_old;
      rob_if.free_en    = 1'b1;
      rob_if.prd_free   = last_e.prd_new;
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: directed scenarios plus random traffic, compared
// every cycle against a queue-based model of the retirement rules.
// Build option: ROB_EXC_EN selects the fault/flush scenarios or the fault-ignored one.
module tb_rob_retire;

  localparam int Depth = 16;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rob_retire_if #(.AW(5), .PW(6), .TW(4)) bus ();

  rob_retire #(
    .ARCH(32), .PHYS(64), .PW(6), .AW(5), .DEPTH(16), .TW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rob_if(bus)
  );

  typedef struct {
    int tag;
    bit has_dst;
    int ard;
    int pnew;
    int pold;
    bit done;
    bit exc;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_tail;
  bit     m_flush;

  int tests;
  int fails;
  int free_log[$];
  int rb_log[$];
  int cprd_log[$];
  int cv_cnt, fs_cnt, fd_cnt;
  int obs_count, obs_ready, obs_tag, obs_cv, obs_free, obs_rb;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic clear_logs();
    free_log.delete();
    rb_log.delete();
    cprd_log.delete();
    cv_cnt = 0;
    fs_cnt = 0;
    fd_cnt = 0;
  endtask

  // Expected outputs for the current cycle, derived from the model's queue.
  task automatic check_outputs();
    int e_ready, e_tag, e_cnt, e_cv, e_card, e_cprd, e_fe, e_free;
    int e_rb, e_rbard, e_rbold, e_fs, e_fd;
    m_ent_t y;
    e_ready = 0; e_tag = 0; e_cnt = 0; e_cv = 0; e_card = 0; e_cprd = 0; e_fe = 0;
    e_free = 0; e_rb = 0; e_rbard = 0; e_rbold = 0; e_fs = 0; e_fd = 0;
    if (rst === 1'b1) begin
      e_cnt = mq.size();
      e_tag = m_tail;
      if (!m_flush) begin
        e_ready = (mq.size() < Depth) ? 1 : 0;
        if (mq.size() > 0 && mq[0].done) begin
          if (mq[0].exc) begin
            e_fs = 1;
          end else begin
            e_cv = 1;
            if (mq[0].has_dst) begin
              e_card = mq[0].ard; e_cprd = mq[0].pnew; e_fe = 1; e_free = mq[0].pold;
            end
          end
        end
      end else if (mq.size() > 0) begin
        y = mq[$];
        if (y.has_dst) begin
          e_rb = 1; e_rbard = y.ard; e_rbold = y.pold; e_fe = 1; e_free = y.pnew;
        end
      end else begin
        e_fd = 1;
      end
    end
    chk("disp_ready", 32'(bus.disp_ready), e_ready);
    chk("disp_tag", 32'(bus.disp_tag), e_tag);
    chk("count", 32'(bus.count), e_cnt);
    chk("commit_valid", 32'(bus.commit_valid), e_cv);
    chk("commit_ard", 32'(bus.commit_ard), e_card);
    chk("commit_prd", 32'(bus.commit_prd), e_cprd);
    chk("free_en", 32'(bus.free_en), e_fe);
    chk("prd_free", 32'(bus.prd_free), e_free);
    chk("rb_valid", 32'(bus.rb_valid), e_rb);
    chk("rb_ard", 32'(bus.rb_ard), e_rbard);
    chk("rb_prd_old", 32'(bus.rb_prd_old), e_rbold);
    chk("flush_start", 32'(bus.flush_start), e_fs);
    chk("flush_done", 32'(bus.flush_done), e_fd);
    obs_count = int'(bus.count);
    obs_ready = int'(bus.disp_ready);
    obs_tag   = int'(bus.disp_tag);
    obs_cv    = int'(bus.commit_valid);
    obs_free  = int'(bus.free_en);
    obs_rb    = int'(bus.rb_valid);
    if (bus.free_en === 1'b1) free_log.push_back(int'(bus.prd_free));
    if (bus.rb_valid === 1'b1) rb_log.push_back(int'(bus.rb_prd_old));
    if (bus.commit_valid === 1'b1) begin
      cv_cnt++;
      cprd_log.push_back(int'(bus.commit_prd));
    end
    if (bus.flush_start === 1'b1) fs_cnt++;
    if (bus.flush_done === 1'b1) fd_cnt++;
  endtask

  // Apply one clock edge's worth of the retirement rules to the model.
  task automatic model_edge();
    bit     ready;
    m_ent_t n;
    if (rst !== 1'b1) begin
      mq.delete();
      m_tail  = 0;
      m_flush = 0;
    end else if (m_flush) begin
      if (mq.size() > 0) begin
        void'(mq.pop_back());
        m_tail = (m_tail + Depth - 1) % Depth;
      end else begin
        m_flush = 0;
      end
    end else begin
      ready = (mq.size() < Depth);
      if (mq.size() > 0 && mq[0].done) begin
        if (mq[0].exc) m_flush = 1;
        else void'(mq.pop_front());
      end
      if (bus.cmpl_valid) begin
        foreach (mq[i]) begin
          if (mq[i].tag == int'(bus.cmpl_tag)) begin
            mq[i].done = 1;
`ifdef ROB_EXC_EN
            mq[i].exc  = bus.cmpl_exc;
`endif
          end
        end
      end
      if (bus.disp_valid && ready) begin
        n.tag = m_tail; n.has_dst = bus.disp_has_dst; n.ard = int'(bus.disp_ard);
        n.pnew = int'(bus.disp_prd_new); n.pold = int'(bus.disp_prd_old);
        n.done = 0; n.exc = 0;
        mq.push_back(n);
        m_tail = (m_tail + 1) % Depth;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    bus.disp_valid = 1'b0;
    bus.cmpl_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic dispatch(input bit hd, input int ard, input int pn, input int po);
    bus.disp_valid   = 1'b1;
    bus.disp_has_dst = hd;
    bus.disp_ard     = 5'(ard);
    bus.disp_prd_new = 6'(pn);
    bus.disp_prd_old = 6'(po);
    step();
    bus.disp_valid   = 1'b0;
  endtask

  task automatic complete(input int tag, input bit exc);
    bus.cmpl_valid = 1'b1;
    bus.cmpl_tag   = 4'(tag);
    bus.cmpl_exc   = exc;
    step();
    bus.cmpl_valid = 1'b0;
    bus.cmpl_exc   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  // Complete outstanding entries one per cycle until the buffer is empty (bounded).
  task automatic drain();
    int budget;
    int pend[$];
    budget = 300;
    bus.disp_valid = 1'b0;
    while ((mq.size() > 0 || m_flush) && budget > 0) begin
      pend.delete();
      foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].tag);
      if (!m_flush && pend.size() > 0) begin
        bus.cmpl_valid = 1'b1;
        bus.cmpl_tag   = 4'(pend[$urandom_range(0, pend.size() - 1)]);
        bus.cmpl_exc   = 1'b0;
      end else begin
        bus.cmpl_valid = 1'b0;
      end
      step();
      budget--;
    end
    bus.cmpl_valid = 1'b0;
    chk("drain_bound", 32'(mq.size()), 0);
  endtask

  initial begin
    int first;
    int pend[$];
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.disp_valid = 1'b0; bus.disp_has_dst = 1'b0; bus.disp_ard = '0;
    bus.disp_prd_new = '0; bus.disp_prd_old = '0;
    bus.cmpl_valid = 1'b0; bus.cmpl_tag = '0; bus.cmpl_exc = 1'b0;
    mq.delete(); m_tail = 0; m_flush = 0;
    clear_logs();

    // Reset state, then ready from the first cycle after release.
    idle(2);
    chk("reset_ready", 32'(obs_ready), 0);
    rst = 1'b1;
    idle(1);
    chk("post_reset_ready", 32'(obs_ready), 1);
    chk("post_reset_count", 32'(obs_count), 0);

    // In-order commit with out-of-order completion.
    clear_logs();
    for (int i = 0; i < 3; i++) dispatch(1'b1, i + 1, 32 + i, i + 1);
    complete(2, 1'b0);
    complete(0, 1'b0);
    complete(1, 1'b0);
    idle(4);
    chk("commit_n", 32'(cprd_log.size()), 3);
    chk("free_n", 32'(free_log.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < cprd_log.size()) chk("commit_prd_seq", 32'(cprd_log[i]), 32'(32 + i));
      if (i < free_log.size()) chk("free_seq", 32'(free_log[i]), 32'(1 + i));
    end

    // Full buffer, no bypass on the commit cycle, tag wrap on the next dispatch.
    do_reset();
    for (int i = 0; i < Depth; i++) dispatch(1'b1, i, 10 + i, 30 + i);
    idle(1);
    chk("full_count", 32'(obs_count), 16);
    chk("full_ready", 32'(obs_ready), 0);
    complete(0, 1'b0);
    idle(1);
    chk("full_commit", 32'(obs_cv), 1);
    chk("full_no_bypass", 32'(obs_ready), 0);
    dispatch(1'b1, 7, 50, 51);
    chk("wrap_ready", 32'(obs_ready), 1);
    chk("wrap_tag", 32'(obs_tag), 0);
    drain();

    // No destination: commit without a free.
    clear_logs();
    dispatch(1'b0, 9, 60, 61);
    complete(obs_tag, 1'b0);
    idle(2);
    chk("nodst_commit", 32'(cv_cnt), 1);
    chk("nodst_free", 32'(free_log.size()), 0);

`ifdef ROB_EXC_EN
    // Fault at head: walk youngest->oldest, then flush_done.
    clear_logs();
    dispatch(1'b1, 1, 40, 5);
    first = obs_tag;
    for (int i = 1; i < 4; i++) dispatch(1'b1, i + 1, 40 + i, 5 + i);
    complete(first, 1'b1);
    idle(7);
    chk("flush_start_n", 32'(fs_cnt), 1);
    chk("flush_done_n", 32'(fd_cnt), 1);
    chk("flush_free_n", 32'(free_log.size()), 4);
    chk("flush_rb_n", 32'(rb_log.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < free_log.size()) chk("flush_free_seq", 32'(free_log[i]), 32'(43 - i));
      if (i < rb_log.size()) chk("flush_rb_seq", 32'(rb_log[i]), 32'(8 - i));
    end
    chk("flush_count", 32'(obs_count), 0);

    // Reset in the middle of a walk.
    dispatch(1'b1, 1, 20, 21);
    first = obs_tag;
    dispatch(1'b1, 2, 22, 23);
    dispatch(1'b1, 3, 24, 25);
    complete(first, 1'b1);
    idle(2);
    rst = 1'b0;
    #1;
    check_outputs();
    chk("midrst_free", 32'(obs_free), 0);
    chk("midrst_rb", 32'(obs_rb), 0);
    chk("midrst_ready", 32'(obs_ready), 0);
    idle(1);
    rst = 1'b1;
    clear_logs();
    idle(3);
    chk("midrst_count", 32'(obs_count), 0);
    chk("midrst_ready_after", 32'(obs_ready), 1);
    chk("midrst_no_frees", 32'(free_log.size()), 0);
`else
    // Fault bit ignored: the head commits normally.
    clear_logs();
    dispatch(1'b1, 4, 44, 45);
    complete(obs_tag, 1'b1);
    idle(3);
    chk("noexc_commit", 32'(cv_cnt), 1);
    chk("noexc_rb", 32'(rb_log.size()), 0);
    chk("noexc_free", 32'(free_log.size()), 1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bus.disp_valid   = ($urandom_range(0, 3) != 0);
      bus.disp_has_dst = ($urandom_range(0, 4) != 0);
      bus.disp_ard     = 5'($urandom_range(0, 31));
      bus.disp_prd_new = 6'($urandom_range(0, 63));
      bus.disp_prd_old = 6'($urandom_range(0, 63));
      bus.cmpl_valid   = ($urandom_range(0, 1) != 0);
      pend.delete();
      foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].tag);
      if (pend.size() > 0 && $urandom_range(0, 3) != 0)
        bus.cmpl_tag = 4'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        bus.cmpl_tag = 4'($urandom_range(0, 15));
      bus.cmpl_exc = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.cmpl_exc = 1'b0;
    drain();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
